// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame parser.
// State encoding, default start-of-frame marker and checksum add.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      PAYLOAD,
      CHK,
      EMIT
   } state_t;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   function automatic logic [7:0] chk_add(
      input logic [7:0] a,
      input logic [7:0] b
   );
      return a + b;
   endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte streams around the frame parser: RX FIFO pop side
// and the verified payload valid/ready side.
interface uart_frame_parser_if;

   logic       i_rx_rdy;
   logic [7:0] i_rx_data;
   logic       o_rx_req;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_last;

   modport master (
      input  i_rx_rdy, i_rx_data, i_ready,
      output o_rx_req, o_data, o_valid, o_last
   );

   modport slave (
      output i_rx_rdy, i_rx_data, i_ready,
      input  o_rx_req, o_data, o_valid, o_last
   );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload store: synchronous write, combinational read,
// independent write/read pointers with a common clear.
module uart_frame_buf #(
   parameter int Depth = 16,
   parameter int PW    = $clog2(Depth + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_adv,
   output logic [7:0]    rd_data,
   output logic [PW-1:0] wr_ptr,
   output logic [PW-1:0] rd_ptr
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [7:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts SOF/LEN/payload/CHK frames in the RX FIFO stream and
// forwards only checksum-verified payloads downstream.
module uart_frame_parser
   import uart_pkg::*;
#(
   parameter int         MaxPayload  = 16,
   parameter logic [7:0] SofByte     = SOF_DEFAULT,
   parameter int         ByteTimeout = 50_000
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   uart_frame_parser_if.master bus,
   output logic                o_frame_ok,
   output logic                o_err_chk,
   output logic                o_err_len,
   output logic                o_err_timeout,
   output logic [15:0]         o_err_count,
   output logic                o_busy
);

   localparam int PW = $clog2(MaxPayload + 1);
   localparam int TW = (ByteTimeout > 1) ? $clog2(ByteTimeout) : 1;
   localparam logic [7:0] MAXL = 8'(MaxPayload);
   localparam logic [TW-1:0] TLIM =
      TW'((ByteTimeout > 0) ? ByteTimeout - 1 : 0);

   state_t        state;
   logic [PW-1:0] len;
   logic [7:0]    sum;
   logic [TW-1:0] tcnt;
   logic [15:0]   err_cnt;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [7:0]    rd_data;
   logic          pop;
   logic          in_frame;
   logic          tmo;
   logic          len_bad;
   logic          chk_bad;
   logic          hs;
   logic          err;

   assign in_frame = state inside {LEN, PAYLOAD, CHK};
   assign pop      = bus.i_rx_rdy && (state != EMIT);
   // A pop in the expiry cycle wins: the byte is taken instead.
   assign tmo      = (ByteTimeout > 0) && in_frame && !pop
                     && (tcnt == TLIM);
   assign len_bad  = (bus.i_rx_data == 8'd0)
                     || (bus.i_rx_data > MAXL);
   assign chk_bad  = chk_add(sum, bus.i_rx_data) != 8'd0;
   assign hs       = bus.o_valid && bus.i_ready;
   assign err      = tmo
                     || (pop && state == LEN && len_bad)
                     || (pop && state == CHK && chk_bad);

   assign bus.o_rx_req = pop;
   assign bus.o_valid  = (state == EMIT);
   assign bus.o_data   = rd_data;
   assign bus.o_last   = bus.o_valid && (rd_ptr == len - PW'(1));
   assign o_busy       = (state != IDLE);
   assign o_err_count  = err_cnt;

   uart_frame_buf #(
      .Depth (MaxPayload),
      .PW    (PW)
   ) u_buf (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .clr     (state == IDLE || state == LEN),
      .wr_en   (pop && state == PAYLOAD),
      .wr_data (bus.i_rx_data),
      .rd_adv  (hs),
      .rd_data (rd_data),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         len           <= '0;
         sum           <= '0;
         tcnt          <= '0;
         err_cnt       <= '0;
         o_frame_ok    <= 1'b0;
         o_err_chk     <= 1'b0;
         o_err_len     <= 1'b0;
         o_err_timeout <= 1'b0;
      end else begin
         o_frame_ok    <= 1'b0;
         o_err_chk     <= 1'b0;
         o_err_len     <= 1'b0;
         o_err_timeout <= 1'b0;
         if (err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         if (pop || !in_frame || tmo) tcnt <= '0;
         else tcnt <= tcnt + TW'(1);
         if (tmo) begin
            o_err_timeout <= 1'b1;
            state         <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (pop && bus.i_rx_data == SofByte) state <= LEN;
               end
               LEN: begin
                  if (pop && len_bad) begin
                     o_err_len <= 1'b1;
                     state     <= IDLE;
                  end else if (pop) begin
                     len   <= bus.i_rx_data[PW-1:0];
                     sum   <= bus.i_rx_data;
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  if (pop) begin
                     sum <= chk_add(sum, bus.i_rx_data);
                     if (wr_ptr == len - PW'(1)) state <= CHK;
                  end
               end
               CHK: begin
                  if (pop && chk_bad) begin
                     o_err_chk <= 1'b1;
                     state     <= IDLE;
                  end else if (pop) begin
                     o_frame_ok <= 1'b1;
                     state      <= EMIT;
                  end
               end
               EMIT: begin
                  if (hs && bus.o_last) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: RX FIFO model,
// expected-payload queue and per-scenario tasks.
module tb_uart_frame_parser;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_frame_parser_if bus ();

   logic        frame_ok;
   logic        err_chk;
   logic        err_len;
   logic        err_tmo;
   logic        busy;
   logic [15:0] err_count;

   uart_frame_parser #(
      .MaxPayload  (16),
      .SofByte     (8'hA5),
      .ByteTimeout (100)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .bus           (bus),
      .o_frame_ok    (frame_ok),
      .o_err_chk     (err_chk),
      .o_err_len     (err_len),
      .o_err_timeout (err_tmo),
      .o_err_count   (err_count),
      .o_busy        (busy)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] rxq [$];
   logic [8:0] expq [$];
   logic [7:0] tmp;
   logic [8:0] e;
   logic [8:0] held_v;
   logic       held = 1'b0;
   logic       prev_last = 1'b0;
   bit         bp = 1'b0;
   bit         rdy_fix = 1'b1;
   int         edges = 0;
   int         last_pop_edge = -1;
   int         n_ok = 0, n_chk = 0, n_len = 0, n_tmo = 0, n_hs = 0;
   int         first_hs = -1, last_hs = -1;
   int         exp_errs = 0;
   int         np;

   // RX FIFO model: pop on the edge, present the new head just after.
   always @(posedge clk) begin
      edges++;
      if (bus.o_rx_req && rxq.size() != 0) begin
         tmp = rxq.pop_front();
         last_pop_edge = edges;
      end
   end

   always @(clk) begin
      #1;
      bus.i_rx_rdy  = rxq.size() != 0;
      bus.i_rx_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
      bus.i_ready   = bp ? (edges % 3 == 0) : rdy_fix;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         held      = 1'b0;
         prev_last = 1'b0;
      end else begin
         np = int'(err_chk) + int'(err_len) + int'(err_tmo);
         if (np > 0) begin
            checks++;
            if (np > 1) begin
               errors++;
               $display("FAIL pulse_excl: got %0d pulses want 1", np);
            end
         end
         n_ok  += int'(frame_ok);
         n_chk += int'(err_chk);
         n_len += int'(err_len);
         n_tmo += int'(err_tmo);
         if (frame_ok) begin
            checks++;
            if (!bus.o_valid || last_pop_edge != edges) begin
               errors++;
               $display("FAIL ok_latency: valid=%0b pop_edge=%0d want %0d",
                        bus.o_valid, last_pop_edge, edges);
            end
         end
         if (bus.o_valid && bus.i_rx_rdy) begin
            checks++;
            if (bus.o_rx_req !== 1'b0) begin
               errors++;
               $display("FAIL emit_pop: got rx_req=%0b want 0", bus.o_rx_req);
            end
         end
         if (held) begin
            checks++;
            if (!bus.o_valid || {bus.o_last, bus.o_data} !== held_v) begin
               errors++;
               $display("FAIL stall_hold: got %0b/%0h want 1/%0h",
                        bus.o_valid, {bus.o_last, bus.o_data}, held_v);
            end
         end
         if (prev_last) begin
            checks++;
            if (bus.o_valid !== 1'b0) begin
               errors++;
               $display("FAIL frame_gap: got valid=%0b want 0", bus.o_valid);
            end
         end
         if (bus.o_valid && bus.i_ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL extra_byte: got %0h want none", bus.o_data);
            end else begin
               e = expq.pop_front();
               if ({bus.o_last, bus.o_data} !== e) begin
                  errors++;
                  $display("FAIL payload: got %0h want %0h",
                           {bus.o_last, bus.o_data}, e);
               end
            end
            n_hs++;
            if (first_hs < 0) first_hs = edges;
            last_hs = edges;
         end
         held      = bus.o_valid && !bus.i_ready;
         held_v    = {bus.o_last, bus.o_data};
         prev_last = bus.o_valid && bus.i_ready && bus.o_last;
      end
   end

   task automatic push_good(input int n, input logic [7:0] seed,
                            input logic [7:0] step);
      logic [7:0] s;
      logic [7:0] d;
      rxq.push_back(8'hA5);
      rxq.push_back(8'(n));
      s = 8'(n);
      for (int i = 0; i < n; i++) begin
         d = seed + 8'(i) * step;
         rxq.push_back(d);
         s = s + d;
         expq.push_back({i == n - 1, d});
      end
      rxq.push_back(8'h00 - s);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((rxq.size() != 0 || busy || expq.size() != 0) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (k >= 2000) begin
         errors++;
         $display("FAIL %s_idle: got busy after %0d cycles want idle", name, k);
      end
   endtask

   task automatic check_count(input string name);
      checks++;
      if (err_count !== 16'(exp_errs)) begin
         errors++;
         $display("FAIL %s_count: got %0h want %0h", name, err_count, exp_errs);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid: got %0b want 0", bus.o_valid);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy: got %0b want 0", busy);
      end
      if (err_count !== 16'h0) begin
         errors++;
         $display("FAIL rst_count: got %0h want 0", err_count);
      end
      if ({frame_ok, err_chk, err_len, err_tmo} !== 4'b0) begin
         errors++;
         $display("FAIL rst_pulses: got %0b want 0",
                  {frame_ok, err_chk, err_len, err_tmo});
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_frame();
      int b_ok = n_ok;
      int b_hs = n_hs;
      first_hs = -1;
      push_good(3, 8'h11, 8'h11);
      wait_idle("good");
      checks += 3;
      if (n_ok - b_ok != 1) begin
         errors++;
         $display("FAIL good_ok: got %0d want 1", n_ok - b_ok);
      end
      if (n_hs - b_hs != 3) begin
         errors++;
         $display("FAIL good_bytes: got %0d want 3", n_hs - b_hs);
      end
      if (last_hs - first_hs != 2) begin
         errors++;
         $display("FAIL good_rate: got %0d cycles want 2", last_hs - first_hs);
      end
      check_count("good");
   endtask

   task automatic test_bad_chk();
      int b_chk = n_chk;
      int b_hs = n_hs;
      int b_ok = n_ok;
      rxq.push_back(8'hA5);
      rxq.push_back(8'h02);
      rxq.push_back(8'h01);
      rxq.push_back(8'h02);
      rxq.push_back(8'h00);
      wait_idle("badchk");
      exp_errs++;
      checks += 2;
      if (n_chk - b_chk != 1) begin
         errors++;
         $display("FAIL chk_pulse: got %0d want 1", n_chk - b_chk);
      end
      if (n_hs != b_hs) begin
         errors++;
         $display("FAIL chk_noemit: got %0d want 0", n_hs - b_hs);
      end
      check_count("badchk");
      push_good(2, 8'h5A, 8'h01);
      wait_idle("afterchk");
      checks++;
      if (n_hs - b_hs != 2 || n_ok - b_ok != 1) begin
         errors++;
         $display("FAIL chk_recover: got %0d/%0d want 2/1",
                  n_hs - b_hs, n_ok - b_ok);
      end
   endtask

   task automatic test_len_err();
      int b_len = n_len;
      int b_other = n_chk + n_tmo;
      int b_hs = n_hs;
      rxq.push_back(8'h00);
      rxq.push_back(8'hFF);
      rxq.push_back(8'hA5);
      rxq.push_back(8'h00);
      rxq.push_back(8'hA5);
      rxq.push_back(8'h11);
      wait_idle("len");
      exp_errs += 2;
      checks += 2;
      if (n_len - b_len != 2) begin
         errors++;
         $display("FAIL len_pulses: got %0d want 2", n_len - b_len);
      end
      if (n_chk + n_tmo != b_other) begin
         errors++;
         $display("FAIL len_junk: got %0d want 0", n_chk + n_tmo - b_other);
      end
      check_count("len");
      push_good(16, 8'h01, 8'h07);
      wait_idle("maxlen");
      checks++;
      if (n_hs - b_hs != 16) begin
         errors++;
         $display("FAIL maxlen_bytes: got %0d want 16", n_hs - b_hs);
      end
   endtask

   task automatic test_back_to_back();
      int b_hs = n_hs;
      int b_ok = n_ok;
      bp = 1'b1;
      push_good(4, 8'hC0, 8'h01);
      push_good(4, 8'h30, 8'h10);
      wait_idle("b2b");
      bp = 1'b0;
      checks++;
      if (n_hs - b_hs != 8 || n_ok - b_ok != 2) begin
         errors++;
         $display("FAIL b2b_frames: got %0d/%0d want 8/2",
                  n_hs - b_hs, n_ok - b_ok);
      end
      check_count("b2b");
   endtask

   task automatic test_timeout();
      int b_hs = n_hs;
      int ep;
      int k;
      logic [7:0] s;
      rxq.push_back(8'hA5);
      rxq.push_back(8'h04);
      rxq.push_back(8'hAA);
      k = 0;
      while (rxq.size() != 0 && k < 50) begin @(negedge clk); k++; end
      ep = last_pop_edge;
      while (edges < ep + 99) @(negedge clk);
      checks += 2;
      if (err_tmo !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL tmo_early: got tmo=%0b busy=%0b want 0/1", err_tmo, busy);
      end
      @(negedge clk);
      if (err_tmo !== 1'b1) begin
         errors++;
         $display("FAIL tmo_pulse: got %0b want 1", err_tmo);
      end
      exp_errs++;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_idle: got busy=%0b want 0", busy);
      end
      s = 8'h04 + 8'hAA + 8'hBB + 8'hCC + 8'hDD;
      expq.push_back({1'b0, 8'hAA});
      expq.push_back({1'b0, 8'hBB});
      expq.push_back({1'b0, 8'hCC});
      expq.push_back({1'b1, 8'hDD});
      rxq.push_back(8'hA5);
      rxq.push_back(8'h04);
      rxq.push_back(8'hAA);
      k = 0;
      while (rxq.size() != 0 && k < 50) begin @(negedge clk); k++; end
      ep = last_pop_edge;
      while (edges < ep + 99) @(negedge clk);
      rxq.push_back(8'hBB);
      @(negedge clk);
      checks += 2;
      if (err_tmo !== 1'b0) begin
         errors++;
         $display("FAIL tmo_edge: got %0b want 0", err_tmo);
      end
      if (last_pop_edge != ep + 100) begin
         errors++;
         $display("FAIL tmo_edge_pop: got %0d want %0d", last_pop_edge, ep + 100);
      end
      rxq.push_back(8'hCC);
      rxq.push_back(8'hDD);
      rxq.push_back(8'h00 - s);
      wait_idle("tmo");
      checks++;
      if (n_hs - b_hs != 4) begin
         errors++;
         $display("FAIL tmo_frame: got %0d want 4", n_hs - b_hs);
      end
      check_count("tmo");
   endtask

   task automatic test_reset_emit();
      int k = 0;
      int b_hs;
      rdy_fix = 1'b0;
      push_good(6, 8'h40, 8'h03);
      while (!bus.o_valid && k < 100) begin @(negedge clk); k++; end
      checks++;
      if (bus.o_valid !== 1'b1) begin
         errors++;
         $display("FAIL remit_reach: got valid=%0b want 1", bus.o_valid);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks += 2;
      if (bus.o_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL remit_state: got valid=%0b busy=%0b want 0/0",
                  bus.o_valid, busy);
      end
      if (err_count !== 16'h0) begin
         errors++;
         $display("FAIL remit_count: got %0h want 0", err_count);
      end
      #2 rst_n = 1'b1;
      expq.delete();
      exp_errs = 0;
      rdy_fix = 1'b1;
      b_hs = n_hs;
      push_good(2, 8'h77, 8'h01);
      wait_idle("remit");
      checks++;
      if (n_hs - b_hs != 2) begin
         errors++;
         $display("FAIL remit_recover: got %0d want 2", n_hs - b_hs);
      end
   endtask

   task automatic test_saturation();
      int b_len = n_len;
      @(negedge clk);
      force dut.err_cnt = 16'hFFFC;
      #1 release dut.err_cnt;
      for (int i = 0; i < 4; i++) begin
         rxq.push_back(8'hA5);
         rxq.push_back(8'h00);
      end
      wait_idle("sat");
      checks += 2;
      if (n_len - b_len != 4) begin
         errors++;
         $display("FAIL sat_pulses: got %0d want 4", n_len - b_len);
      end
      if (err_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_count: got %0h want ffff", err_count);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      bus.i_rx_rdy  = 1'b0;
      bus.i_rx_data = 8'h00;
      bus.i_ready   = 1'b1;
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_len_err();
      test_back_to_back();
      test_timeout();
      test_reset_emit();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
